mips_wb_queue: RTL



---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_wb_queue_if.sv | 41 ++++
 rtl/mips_wb_match.sv | 34 +++
 rtl/mips_wb_queue.sv | 107 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS write-back types: register/data widths, the $zero index and the queue entry.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/mips_wb_queue_if.sv
// Producer, register-file write port and hazard-check signals of the write-back queue.
// MIPS_WB_BYPASS_EN adds the forwarding value outputs.
interface mips_wb_queue_if;
    import mips_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              read_req;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] chk_reg_1;
    logic [ADDR_W-1:0] chk_reg_2;
    logic              hit_1;
    logic              hit_2;
    logic              busy;
`ifdef MIPS_WB_BYPASS_EN
    logic              fwd_valid_1;
    logic              fwd_valid_2;
    logic [DATA_W-1:0] fwd_data_1;
    logic [DATA_W-1:0] fwd_data_2;
`endif

    modport master (
        output in_valid, in_reg, in_data, read_req, chk_reg_1, chk_reg_2,
        input  in_ready, reg_write, write_reg, write_data, hit_1, hit_2, busy
`ifdef MIPS_WB_BYPASS_EN
        , input fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
`endif
    );

    modport slave (
        input  in_valid, in_reg, in_data, read_req, chk_reg_1, chk_reg_2,
        output in_ready, reg_write, write_reg, write_data, hit_1, hit_2, busy
`ifdef MIPS_WB_BYPASS_EN
        , output fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
`endif
    );
endinterface

// File: rtl/mips_wb_match.sv
// Associative lookup of one source register against the queued entries (oldest first)
// and the in-flight write; reports a hit and the youngest matching value.
module mips_wb_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t         i_entries [DEPTH],
    input  logic [DEPTH-1:0]  i_valid,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_reg,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_chk_reg,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);
    // In-flight write is oldest; later queue matches overwrite it so the youngest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        if (i_chk_reg != REG_ZERO) begin
            if (i_wr_en && (i_wr_reg == i_chk_reg)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (i_valid[k] && (i_entries[k].dst == i_chk_reg)) begin
                    o_hit  = 1'b1;
                    o_data = i_entries[k].data;
                end
            end
        end
    end
endmodule

// File: rtl/mips_wb_queue.sv
// Write-back FIFO between execute units and the register-file write port, with hazard lookup.
// Optional MIPS_WB_BYPASS_EN: exports the youngest pending value for forwarding.
module mips_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_wb_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_age [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [DATA_W-1:0] w_fwd_data_1;
    logic [DATA_W-1:0] w_fwd_data_2;

    assign bus.in_ready = (r_count < CNT_W'(DEPTH));
    // Writes to $zero complete the handshake but are dropped.
    assign w_push = bus.in_valid && bus.in_ready && (bus.in_reg != REG_ZERO);
    assign w_pop  = (r_count != '0) && !bus.read_req;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{dst: bus.in_reg, data: bus.in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_reg_write <= w_pop;
            if (w_pop) begin
                r_write_reg  <= r_mem[r_rd_ptr].dst;
                r_write_data <= r_mem[r_rd_ptr].data;
            end
        end
    end

    // Rotate storage into age order (index 0 = head) for the lookups.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_age[k] = r_mem[r_rd_ptr + PTR_W'(k)];
            w_vld[k] = (CNT_W'(k) < r_count);
        end
    end

    mips_wb_match #(.DEPTH(DEPTH)) u_match_1 (
        .i_entries (w_age),
        .i_valid   (w_vld),
        .i_wr_en   (r_reg_write),
        .i_wr_reg  (r_write_reg),
        .i_wr_data (r_write_data),
        .i_chk_reg (bus.chk_reg_1),
        .o_hit     (bus.hit_1),
        .o_data    (w_fwd_data_1)
    );

    mips_wb_match #(.DEPTH(DEPTH)) u_match_2 (
        .i_entries (w_age),
        .i_valid   (w_vld),
        .i_wr_en   (r_reg_write),
        .i_wr_reg  (r_write_reg),
        .i_wr_data (r_write_data),
        .i_chk_reg (bus.chk_reg_2),
        .o_hit     (bus.hit_2),
        .o_data    (w_fwd_data_2)
    );

    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.busy       = (r_count != '0) || r_reg_write;

`ifdef MIPS_WB_BYPASS_EN
    assign bus.fwd_valid_1 = bus.hit_1;
    assign bus.fwd_valid_2 = bus.hit_2;
    assign bus.fwd_data_1  = w_fwd_data_1;
    assign bus.fwd_data_2  = w_fwd_data_2;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_fwd_data_1, w_fwd_data_2};
`endif
endmodule
